// File: rtl/complex_alu_pkg.sv
// Opcodes, FSM encodings and the narrowing helper shared by the complex ALU pipeline.
package complex_alu_pkg;

  localparam int unsigned OP_SIZE = 4;

  typedef logic [OP_SIZE-1:0] op_t;

  localparam op_t OpAdd       = 4'b0000;
  localparam op_t OpSub       = 4'b0001;
  localparam op_t OpMul       = 4'b0010;
  localparam op_t OpReal      = 4'b0100;
  localparam op_t OpImag      = 4'b0101;
  localparam op_t OpConj      = 4'b0110;
  localparam op_t OpLess      = 4'b1001;
  localparam op_t OpEqual     = 4'b1010;
  localparam op_t OpLore      = 4'b1011;
  localparam op_t OpGreat     = 4'b1100;
  localparam op_t OpNequal    = 4'b1101;
  localparam op_t OpGore      = 4'b1110;
  localparam op_t OpMemAccess = 4'b1111;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StMul1 = 3'd1;
  localparam state_t StMul2 = 3'd2;
  localparam state_t StMul3 = 3'd3;
  localparam state_t StMul4 = 3'd4;

  // Clamp (sat) or wrap a sign-extended value into a w-bit signed range; w must lie in 2..31.
  function automatic logic signed [31:0] narrow(input logic signed [31:0] v,
                                                input int unsigned      w,
                                                input logic             sat);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    int unsigned        sh;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    sh = 32 - w;
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return (v <<< sh) >>> sh;
  endfunction

endpackage

// File: rtl/complex_alu_pipe_mul.sv
// Iterative complex multiplier: one shared W x W signed multiplier stepped over four states.
module complex_mul_iter
  import complex_alu_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned FRAC = 0,
  parameter bit          SAT  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic signed [W-1:0] a_re_i,
  input  logic signed [W-1:0] a_im_i,
  input  logic signed [W-1:0] b_re_i,
  input  logic signed [W-1:0] b_im_i,
  input  logic                load_ok_i,
  output logic                busy_o,
  output logic                done_o,
  output logic signed [W-1:0] re_o,
  output logic signed [W-1:0] im_o
);

  state_t state_q, state_d;
  logic signed [W-1:0]   ar_q, ai_q, br_q, bi_q;
  logic signed [W-1:0]   re_q, re_d;
  logic signed [W-1:0]   mul_x, mul_y;
  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   prod_ext, acc_q, acc_d, sum;
  logic signed [W-1:0]   sum_nar;

  always_comb begin
    mul_x = ar_q;
    mul_y = br_q;
    case (state_q)
      StMul2:  begin mul_x = ai_q; mul_y = bi_q; end
      StMul3:  begin mul_x = ar_q; mul_y = bi_q; end
      StMul4:  begin mul_x = ai_q; mul_y = br_q; end
      default: ;
    endcase
  end

  assign prod     = mul_x * mul_y;
  assign prod_ext = {prod[2*W-1], prod};
  // MUL2 subtracts bd from ac; MUL4 adds bc to ad.
  assign sum      = (state_q == StMul2) ? (acc_q - prod_ext) : (acc_q + prod_ext);
  assign sum_nar  = W'(narrow(32'(sum >>> FRAC), W, SAT));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    re_d    = re_q;
    case (state_q)
      StIdle: if (start_i) state_d = StMul1;
      StMul1: begin acc_d = prod_ext; state_d = StMul2; end
      StMul2: begin acc_d = sum; re_d = sum_nar; state_d = StMul3; end
      StMul3: begin acc_d = prod_ext; state_d = StMul4; end
      // Hold here until the output register can take the result.
      StMul4: if (load_ok_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      re_q    <= '0;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      re_q    <= re_d;
      if (start_i && (state_q == StIdle)) begin
        ar_q <= a_re_i;
        ai_q <= a_im_i;
        br_q <= b_re_i;
        bi_q <= b_im_i;
      end
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StMul4) && load_ok_i;
  assign re_o   = re_q;
  assign im_o   = sum_nar;

endmodule

// File: rtl/complex_alu_pipe.sv
// Handshaked complex ALU: single-cycle simple ops, 4-cycle iterative multiply, one output register.
module complex_alu_pipe
  import complex_alu_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned FRAC = 0,
  parameter bit          SAT  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [OP_SIZE-1:0]  op_i,
  input  logic signed [W-1:0] a_re_i,
  input  logic signed [W-1:0] a_im_i,
  input  logic signed [W-1:0] b_re_i,
  input  logic signed [W-1:0] b_im_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic signed [W-1:0] out_re_o,
  output logic signed [W-1:0] out_im_o,
  output logic                comp_o,
  output logic                err_o
);

  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic                comp_q, comp_d, err_q, err_d;
  logic signed [W-1:0] res_re, res_im;
  logic                res_comp, res_err;
  logic                load_ok, accept, alu_load, mul_start;
  logic                mul_busy, mul_done;
  logic signed [W-1:0] mul_re, mul_im;

  assign load_ok    = !out_valid_q || out_ready_i;
  assign in_ready_o = !mul_busy && load_ok;
  assign accept     = in_valid_i && in_ready_o;
  assign alu_load   = accept && (op_i != OpMul);
  assign mul_start  = accept && (op_i == OpMul);

  complex_mul_iter #(
    .W   (W),
    .FRAC(FRAC),
    .SAT (SAT)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .a_re_i   (a_re_i),
    .a_im_i   (a_im_i),
    .b_re_i   (b_re_i),
    .b_im_i   (b_im_i),
    .load_ok_i(load_ok),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .re_o     (mul_re),
    .im_o     (mul_im)
  );

  always_comb begin
    res_re   = '0;
    res_im   = '0;
    res_comp = 1'b0;
    res_err  = 1'b0;
    case (op_i)
      OpAdd: begin
        res_re = W'(narrow(32'(a_re_i) + 32'(b_re_i), W, SAT));
        res_im = W'(narrow(32'(a_im_i) + 32'(b_im_i), W, SAT));
      end
      OpSub: begin
        res_re = W'(narrow(32'(a_re_i) - 32'(b_re_i), W, SAT));
        res_im = W'(narrow(32'(a_im_i) - 32'(b_im_i), W, SAT));
      end
      OpMul:  ;
      OpReal: res_re = a_re_i;
      OpImag: res_re = a_im_i;
      OpConj: begin
        res_re = a_re_i;
        res_im = W'(narrow(-32'(a_im_i), W, SAT));
      end
      OpLess:   res_comp = (a_re_i <  b_re_i);
      OpLore:   res_comp = (a_re_i <= b_re_i);
      OpGreat:  res_comp = (a_re_i >  b_re_i);
      OpGore:   res_comp = (a_re_i >= b_re_i);
      OpEqual:  res_comp = (a_re_i == b_re_i) && (a_im_i == b_im_i);
      OpNequal: res_comp = (a_re_i != b_re_i) || (a_im_i != b_im_i);
      // Address arithmetic always wraps.
      OpMemAccess: begin
        res_re = W'(narrow(32'(a_re_i) + 32'(b_re_i), W, 1'b0));
        res_im = W'(narrow(32'(a_im_i) + 32'(b_im_i), W, 1'b0));
      end
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    comp_d      = comp_q;
    err_d       = err_q;
    if (alu_load) begin
      out_valid_d = 1'b1;
      out_re_d    = res_re;
      out_im_d    = res_im;
      comp_d      = res_comp;
      err_d       = res_err;
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      out_re_d    = mul_re;
      out_im_d    = mul_im;
      comp_d      = 1'b0;
      err_d       = 1'b0;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      comp_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      comp_q      <= comp_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_re_o    = out_re_q;
  assign out_im_o    = out_im_q;
  assign comp_o      = comp_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_complex_alu_pipe.sv
// Bench for complex_alu_pipe: a saturating and a wrapping instance share one input bus.
module tb_complex_alu_pipe;
  import complex_alu_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  op_t  op = '0;
  logic signed [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

  logic s_in_ready, s_out_valid, s_comp, s_err;
  logic signed [W-1:0] s_re, s_im;
  logic w_in_ready, w_out_valid, w_comp, w_err;
  logic signed [W-1:0] w_re, w_im;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  complex_alu_pipe #(.W(W), .FRAC(0), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready), .op_i(op),
    .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im), .out_valid_o(s_out_valid),
    .out_ready_i(out_ready), .out_re_o(s_re), .out_im_o(s_im), .comp_o(s_comp), .err_o(s_err)
  );

  complex_alu_pipe #(.W(W), .FRAC(0), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(w_in_ready), .op_i(op),
    .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im), .out_valid_o(w_out_valid),
    .out_ready_i(out_ready), .out_re_o(w_re), .out_im_o(w_im), .comp_o(w_comp), .err_o(w_err)
  );

  function automatic logic [7:0] fit(input int v, input bit s);
    if (s && v > 127) return 8'h7f;
    if (s && v < -128) return 8'h80;
    return v[7:0];
  endfunction

  // Reference: {re, im, comp, err} from plain integer arithmetic.
  function automatic logic [17:0] model(input op_t o, input logic signed [7:0] ar, ai, br, bi,
                                        input bit sat);
    int   r = 0;
    int   i = 0;
    logic c = 1'b0;
    logic e = 1'b0;
    bit   s = sat;
    case (o)
      4'd0:  begin r = ar + br; i = ai + bi; end
      4'd1:  begin r = ar - br; i = ai - bi; end
      4'd2:  begin r = ar * br - ai * bi; i = ar * bi + ai * br; end
      4'd4:  r = ar;
      4'd5:  r = ai;
      4'd6:  begin r = ar; i = -ai; end
      4'd9:  c = (ar < br);
      4'd10: c = (ar == br) && (ai == bi);
      4'd11: c = (ar <= br);
      4'd12: c = (ar > br);
      4'd13: c = !((ar == br) && (ai == bi));
      4'd14: c = (ar >= br);
      4'd15: begin r = ar + br; i = ai + bi; s = 1'b0; end
      default: e = 1'b1;
    endcase
    return {fit(r, s), fit(i, s), c, e};
  endfunction

  // Present an op and return 1 time unit after the edge that accepts it.
  task automatic issue(input op_t o, input logic signed [7:0] ar, ai, br, bi);
    int guard = 0;
    op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_valid = 1'b1;
    #1;
    while (!s_in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard == 20) begin
      n_checks++;
      $display("FAIL issue_timeout: in_ready=%b required 1", s_in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the bus: captured operands must not depend on it any more.
    op = op_t'($urandom_range(15, 0));
    a_re = 8'($urandom); a_im = 8'($urandom); b_re = 8'($urandom); b_im = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({s_out_valid, s_re, s_im, s_comp, s_err} !== 19'd0)
      $display("FAIL reset_sat: got %h required 0", {s_out_valid, s_re, s_im, s_comp, s_err});
    else n_pass++;
    n_checks++;
    if ({w_out_valid, w_re, w_im, w_comp, w_err} !== 19'd0)
      $display("FAIL reset_wrap: got %h required 0", {w_out_valid, w_re, w_im, w_comp, w_err});
    else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({s_in_ready, s_out_valid, w_in_ready, w_out_valid} !== 4'b1010)
      $display("FAIL reset_ready: got %b required 1010",
               {s_in_ready, s_out_valid, w_in_ready, w_out_valid});
    else n_pass++;
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(OpAdd, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    n_checks++;
    if ({s_out_valid, s_re, s_im, s_comp, s_err} !== {1'b1, 8'd12, 8'd14, 2'b00})
      $display("FAIL add: got %h required %h", {s_out_valid, s_re, s_im, s_comp, s_err},
               {1'b1, 8'd12, 8'd14, 2'b00});
    else n_pass++;
    issue(OpSub, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    n_checks++;
    if ({s_out_valid, s_re, s_im, s_comp, s_err} !== {1'b1, 8'hfe, 8'hfe, 2'b00})
      $display("FAIL sub: got %h required %h", {s_out_valid, s_re, s_im, s_comp, s_err},
               {1'b1, 8'hfe, 8'hfe, 2'b00});
    else n_pass++;
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    issue(OpMul, 8'sd1, 8'sd1, 8'sd1, 8'sd1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({s_in_ready, s_out_valid} !== 2'b00)
        $display("FAIL mul_busy[%0d]: in_ready,out_valid=%b required 00", k,
                 {s_in_ready, s_out_valid});
      else n_pass++;
      if (k < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({s_out_valid, s_re, s_im, s_comp, s_err} !== {1'b1, 8'd0, 8'd2, 2'b00})
      $display("FAIL mul_1p1j_sq: got %h required %h", {s_out_valid, s_re, s_im, s_comp, s_err},
               {1'b1, 8'd0, 8'd2, 2'b00});
    else n_pass++;

    issue(OpMul, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({s_out_valid, s_re, s_im, w_re, w_im} !== {1'b1, 8'hf3, 8'd82, 8'hf3, 8'd82})
      $display("FAIL mul_5_6_7_8: got %h required %h", {s_out_valid, s_re, s_im, w_re, w_im},
               {1'b1, 8'hf3, 8'd82, 8'hf3, 8'd82});
    else n_pass++;

    issue(OpMul, 8'sd100, 8'sd0, 8'sd2, 8'sd0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({s_re, s_im, w_re, w_im} !== {8'd127, 8'd0, 8'hc8, 8'd0})
      $display("FAIL mul_overflow: got %h required %h", {s_re, s_im, w_re, w_im},
               {8'd127, 8'd0, 8'hc8, 8'd0});
    else n_pass++;
  endtask

  task automatic test_sat();
    issue(OpAdd, 8'sd100, 8'sd0, 8'sd100, 8'sd0);
    n_checks++;
    if ({s_re, s_im, w_re, w_im} !== {8'd127, 8'd0, 8'hc8, 8'd0})
      $display("FAIL add_overflow: got %h required %h", {s_re, s_im, w_re, w_im},
               {8'd127, 8'd0, 8'hc8, 8'd0});
    else n_pass++;
    issue(OpConj, 8'sd5, 8'sh80, 8'sd0, 8'sd0);
    n_checks++;
    if ({s_re, s_im, w_re, w_im} !== {8'd5, 8'd127, 8'd5, 8'h80})
      $display("FAIL conj_min: got %h required %h", {s_re, s_im, w_re, w_im},
               {8'd5, 8'd127, 8'd5, 8'h80});
    else n_pass++;
  endtask

  task automatic test_compare();
    op_t  ops [6] = '{OpLess, OpEqual, OpLore, OpNequal, OpGreat, OpGore};
    logic exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      issue(ops[k], 8'sd5, 8'sd6, 8'sd7, 8'sd8);
      n_checks++;
      if ({s_out_valid, s_re, s_im, s_comp, s_err} !== {1'b1, 16'd0, exp[k], 1'b0})
        $display("FAIL compare op=%h: got %h required %h", ops[k],
                 {s_out_valid, s_re, s_im, s_comp, s_err}, {1'b1, 16'd0, exp[k], 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int moved = 0;
    out_ready = 1'b1;
    issue(OpAdd, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    out_ready = 1'b0;
    op = OpSub; a_re = 8'sd5; a_im = 8'sd6; b_re = 8'sd7; b_im = 8'sd8;
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if ({s_in_ready, s_out_valid, s_re, s_im} !== {2'b01, 8'd12, 8'd14}) moved++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (moved != 0) $display("FAIL bp_hold: %0d stalled cycles differ, required 0", moved);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (s_in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b required 1", s_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if ({s_out_valid, s_re, s_im} !== {1'b1, 8'hfe, 8'hfe})
      $display("FAIL bp_next: got %h required %h", {s_out_valid, s_re, s_im},
               {1'b1, 8'hfe, 8'hfe});
    else n_pass++;

    // A finished multiply stays put while the consumer stalls, then retires.
    issue(OpMul, 8'sd1, 8'sd1, 8'sd1, 8'sd1);
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    moved = 0;
    for (int k = 0; k < 3; k++) begin
      if ({s_out_valid, s_re, s_im} !== {1'b1, 8'd0, 8'd2}) moved++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (moved != 0) $display("FAIL bp_mul_hold: %0d cycles differ, required 0", moved);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (s_out_valid !== 1'b0) $display("FAIL bp_retire: out_valid=%b required 0", s_out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    op_t o;
    logic signed [7:0] ar, ai, br, bi;
    logic [17:0] es, ew;
    out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      o = OpMul;
      while (o == OpMul) o = op_t'($urandom_range(15, 0));
      ar = 8'($urandom); ai = 8'($urandom); br = 8'($urandom); bi = 8'($urandom);
      op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi;
      in_valid = 1'b1;
      #1;
      n_checks++;
      if (s_in_ready !== 1'b1) $display("FAIL b2b_ready n=%0d: got %b required 1", n, s_in_ready);
      else n_pass++;
      @(posedge clk); #1;
      es = model(o, ar, ai, br, bi, 1'b1);
      ew = model(o, ar, ai, br, bi, 1'b0);
      n_checks++;
      if ({s_out_valid, s_re, s_im, s_comp, s_err, w_re, w_im, w_comp, w_err} !== {1'b1, es, ew})
        $display("FAIL b2b op=%h a=%h,%h b=%h,%h: got %h required %h", o, ar, ai, br, bi,
                 {s_out_valid, s_re, s_im, s_comp, s_err, w_re, w_im, w_comp, w_err},
                 {1'b1, es, ew});
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    op_t o;
    logic signed [7:0] ar, ai, br, bi;
    logic [17:0] es, ew;
    int lat;
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      o = (n % 3 == 0) ? OpMul : op_t'($urandom_range(15, 0));
      ar = 8'($urandom); ai = 8'($urandom); br = 8'($urandom); bi = 8'($urandom);
      issue(o, ar, ai, br, bi);
      lat = 0;
      while (!s_out_valid && lat < 8) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (lat != ((o == OpMul) ? 4 : 0))
        $display("FAIL rand_latency op=%h: got %0d edges required %0d", o, lat,
                 (o == OpMul) ? 4 : 0);
      else n_pass++;
      es = model(o, ar, ai, br, bi, 1'b1);
      ew = model(o, ar, ai, br, bi, 1'b0);
      n_checks++;
      if ({s_re, s_im, s_comp, s_err, w_re, w_im, w_comp, w_err} !== {es, ew})
        $display("FAIL rand op=%h a=%h,%h b=%h,%h: got %h required %h", o, ar, ai, br, bi,
                 {s_re, s_im, s_comp, s_err, w_re, w_im, w_comp, w_err}, {es, ew});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_mul();
    int stray = 0;
    out_ready = 1'b1;
    issue(OpMul, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_out_valid, s_in_ready} !== 2'b01)
      $display("FAIL rst_mid_mul: out_valid,in_ready=%b required 01", {s_out_valid, s_in_ready});
    else n_pass++;
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (s_out_valid !== 1'b0 || w_out_valid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) $display("FAIL rst_no_result: %0d cycles valid, required 0", stray);
    else n_pass++;
    issue(OpMemAccess, 8'sd0, 8'shff, 8'sd0, 8'sd10);
    n_checks++;
    if ({s_out_valid, s_re, s_im, w_re, w_im} !== {1'b1, 8'd0, 8'd9, 8'd0, 8'd9})
      $display("FAIL mem_access: got %h required %h", {s_out_valid, s_re, s_im, w_re, w_im},
               {1'b1, 8'd0, 8'd9, 8'd0, 8'd9});
    else n_pass++;
    issue(4'b0011, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
    n_checks++;
    if ({s_out_valid, s_re, s_im, s_comp, s_err} !== {1'b1, 16'd0, 2'b01})
      $display("FAIL illegal_op: got %h required %h", {s_out_valid, s_re, s_im, s_comp, s_err},
               {1'b1, 16'd0, 2'b01});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_sat();
    test_compare();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
